tb_doutb_seq_ctrl: RTL and testbench
====================================

// Module: tb_doutb_seq_ctrl
// PURPOSE
//  Sequencer for the TB port-B read path. Accepts one read-out command, issues TB_enb/TB_addrb,
//  and drives TB_doutb_sel, seq_cnt_out and l_k_0 so they align with TB_doutb at the map stage.
//  Covers B streaming (POS/NEG/NEW) and the H_lv_H / cov_HT transposes into B_cache.
// PARAMETERS
//  SEQ_CNT_DW       5   width of seq_cnt_out and cmd_len
//  TB_AW           10   TB port-B address width
//  TB_DOUTB_SEL_DW  5   width of TB_doutb_sel
//  RD_LAT           1   TB read latency in cycles (>=1)
// PORTS
//  clk           in   1                single clock, rising edge
//  sys_rst       in   1                synchronous reset, active-high
//  cmd_valid     in   1                command request
//  cmd_ready     out  1                high only in IDLE; accept = cmd_valid & cmd_ready
//  cmd_op        in   3                0 B_POS, 1 B_NEG, 2 B_NEW, 3 H_lv_H_T, 4 cov_HT_T, 5-7 illegal
//  cmd_l_k_0     in   1                landmark-slot flag for B_NEW / cov_HT_T
//  cmd_base      in   TB_AW            first TB row address
//  cmd_len       in   SEQ_CNT_DW       row count for B ops; ignored for transposes
//  TB_enb        out  1                TB port-B read enable
//  TB_addrb      out  TB_AW            TB port-B read address
//  TB_doutb_sel  out  TB_DOUTB_SEL_DW  map select, aligned with TB_doutb
//  seq_cnt_out   out  SEQ_CNT_DW       sequence index, aligned with TB_doutb
//  l_k_0         out  1                latched cmd_l_k_0
//  busy          out  1                ~cmd_ready
//  done          out  1                one-cycle completion pulse
// BEHAVIOUR
//  - Reset: all outputs 0 except cmd_ready=1; FSM to IDLE. Applies mid-operation, same cycle;
//    in-flight reads are abandoned and sel/seq_cnt_out return to 0 immediately.
//  - FSM: IDLE -(accept)-> ISSUE -(last c issued)-> DRAIN -(RD_LAT cycles)-> IDLE, done=1 on that
//    IDLE-entry cycle. cmd_ready=1 in the done cycle, so back-to-back accept is allowed.
//    cmd_valid while busy is ignored, with no side effects.
//  - Internal counter c, per op, one value per cycle:
//      B_*:      c=0..len-1,  addr=base+c
//      H_lv_H_T: c=12..14,    addr=base+min(c-12,1)
//      cov_HT_T: c=4..10,     addr=base+min(c-4,3)
//    Every c issues a read, so N = number of c values (len, 3 or 7).
//  - Timing, accept at cycle T: TB_enb/TB_addrb registered, valid T+1..T+N.
//    seq_cnt_out=c and TB_doutb_sel are delayed RD_LAT, valid T+1+RD_LAT..T+RD_LAT+N, 0 otherwise.
//    done at T+1+RD_LAT+N.
//  - TB_doutb_sel, {sel[4:2],sel[1:0]}:
//      B_POS 00101, B_NEG 00110, B_NEW 00111, H_lv_H_T 10100, cov_HT_T 11000, idle 00000.
//  - l_k_0 loads cmd_l_k_0 on accept and holds until the next accept.
//  - Zero-length B command (len=0) or illegal op: no TB_enb and sel stays 0; done at T+1+RD_LAT.
//  - Address arithmetic wraps modulo 2^TB_AW; no overflow flag.
//  - TB_enb=0 forces TB_addrb=0.
// TESTING (RD_LAT=1)
//  - B_POS base=0x010 len=4 @T -> addrb 0x010..0x013 T+1..T+4; sel=00101, seq 0..3 T+2..T+5; done T+6.
//  - B_NEG base=0x3FF len=2 -> addrb 0x3FF,0x000 (wrap); sel=00110 T+2..T+3; done T+4.
//  - cov_HT_T l_k_0=1 base=0x020 -> addrb 20,21,22,23,23,23,23 T+1..T+7; seq 4..10 T+2..T+8;
//    sel=11000; l_k_0=1; done T+9.
//  - H_lv_H_T base=0x040 -> addrb 40,41,41; seq 12,13,14 T+2..T+4; sel=10100; done T+5.
//  - len=0 B_POS, then op=6 -> TB_enb never 1; sel 0; done T+2 each; both accepted.
//  - cmd_valid held high while busy -> exactly one accept per done;
//    sys_rst at T+3 of cov_HT -> T+4: all outputs 0, cmd_ready=1, no done.

Source files
------------

// File: rtl/tb_doutb_seq_ctrl.sv
// TB port-B read sequencer.
// Takes one read-out command at a time and issues TB_enb/TB_addrb for it.
// The map select and the sequence index are delayed by the TB read latency,
// so they line up with TB_doutb when it reaches the map stage.
module tb_doutb_seq_ctrl #(
    parameter int SEQ_CNT_DW      = 5,
    parameter int TB_AW           = 10,
    parameter int TB_DOUTB_SEL_DW = 5,
    parameter int RD_LAT          = 1
) (
    input  logic                       clk,
    input  logic                       sys_rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic                       cmd_l_k_0,
    input  logic [TB_AW-1:0]           cmd_base,
    input  logic [SEQ_CNT_DW-1:0]      cmd_len,
    output logic                       TB_enb,
    output logic [TB_AW-1:0]           TB_addrb,
    output logic [TB_DOUTB_SEL_DW-1:0] TB_doutb_sel,
    output logic [SEQ_CNT_DW-1:0]      seq_cnt_out,
    output logic                       l_k_0,
    output logic                       busy,
    output logic                       done
);

    localparam logic [2:0] OP_B_POS = 3'd0;
    localparam logic [2:0] OP_B_NEG = 3'd1;
    localparam logic [2:0] OP_B_NEW = 3'd2;
    localparam logic [2:0] OP_H_T   = 3'd3;
    localparam logic [2:0] OP_COV_T = 3'd4;

    localparam int DRAIN_CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Per-command context captured on accept
    logic [2:0]                 r_op;
    logic [TB_AW-1:0]           r_base;
    logic [TB_DOUTB_SEL_DW-1:0] r_sel;
    logic [SEQ_CNT_DW-1:0]      r_idx;      // index of the read currently on the port
    logic [SEQ_CNT_DW-1:0]      r_last;     // index of the final read
    logic [SEQ_CNT_DW-1:0]      r_c;        // c value of the read currently on the port
    logic                       r_enb;
    logic [TB_AW-1:0]           r_addrb;
    logic                       r_l_k_0;
    logic                       r_done;
    logic [DRAIN_CW-1:0]        r_drain_cnt;

    // Delay line carrying c and sel alongside the TB read latency
    logic [SEQ_CNT_DW-1:0]      r_pipe_c   [RD_LAT];
    logic [TB_DOUTB_SEL_DW-1:0] r_pipe_sel [RD_LAT];

    // Decoded incoming command
    logic [SEQ_CNT_DW-1:0]      w_cmd_n;
    logic [SEQ_CNT_DW-1:0]      w_cmd_c0;
    logic [TB_DOUTB_SEL_DW-1:0] w_cmd_sel;

    logic                       w_accept;
    logic                       w_issue_last;
    logic                       w_drain_last;
    logic [SEQ_CNT_DW-1:0]      w_next_idx;
    logic [TB_AW-1:0]           w_next_off;

    assign w_accept     = cmd_valid && (r_state == ST_IDLE);
    assign w_issue_last = (r_idx == r_last);
    assign w_drain_last = (r_drain_cnt == DRAIN_CW'(RD_LAT - 1));
    assign w_next_idx   = r_idx + SEQ_CNT_DW'(1);

    // Decode read count, first c value and map select of the offered command
    always_comb begin
        w_cmd_n   = '0;
        w_cmd_c0  = '0;
        w_cmd_sel = '0;
        case (cmd_op)
            OP_B_POS: begin
                w_cmd_n   = cmd_len;
                w_cmd_sel = TB_DOUTB_SEL_DW'(5'b00101);
            end
            OP_B_NEG: begin
                w_cmd_n   = cmd_len;
                w_cmd_sel = TB_DOUTB_SEL_DW'(5'b00110);
            end
            OP_B_NEW: begin
                w_cmd_n   = cmd_len;
                w_cmd_sel = TB_DOUTB_SEL_DW'(5'b00111);
            end
            OP_H_T: begin
                w_cmd_n   = SEQ_CNT_DW'(3);
                w_cmd_c0  = SEQ_CNT_DW'(12);
                w_cmd_sel = TB_DOUTB_SEL_DW'(5'b10100);
            end
            OP_COV_T: begin
                w_cmd_n   = SEQ_CNT_DW'(7);
                w_cmd_c0  = SEQ_CNT_DW'(4);
                w_cmd_sel = TB_DOUTB_SEL_DW'(5'b11000);
            end
            default: begin
                // illegal ops issue nothing and complete like a zero-length read
            end
        endcase
    end

    // Row offset of the next read; transposes revisit their final row
    always_comb begin
        w_next_off = TB_AW'(w_next_idx);
        case (r_op)
            OP_H_T:   if (w_next_idx > SEQ_CNT_DW'(1)) w_next_off = TB_AW'(1);
            OP_COV_T: if (w_next_idx > SEQ_CNT_DW'(3)) w_next_off = TB_AW'(3);
            default:  w_next_off = TB_AW'(w_next_idx);
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_cmd_n == '0) ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_issue_last) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_drain_last) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Issue datapath: capture command, step the read address, time the drain
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_op        <= '0;
            r_base      <= '0;
            r_sel       <= '0;
            r_idx       <= '0;
            r_last      <= '0;
            r_c         <= '0;
            r_enb       <= 1'b0;
            r_addrb     <= '0;
            r_l_k_0     <= 1'b0;
            r_done      <= 1'b0;
            r_drain_cnt <= '0;
        end else begin
            r_done <= (r_state == ST_DRAIN) && w_drain_last;

            if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + DRAIN_CW'(1);
            end else begin
                r_drain_cnt <= '0;
            end

            if (w_accept) begin
                r_op    <= cmd_op;
                r_base  <= cmd_base;
                r_sel   <= w_cmd_sel;
                r_l_k_0 <= cmd_l_k_0;
                r_idx   <= '0;
                r_last  <= w_cmd_n - SEQ_CNT_DW'(1);
                r_c     <= w_cmd_c0;
                r_enb   <= (w_cmd_n != '0);
                // every op starts at offset 0
                r_addrb <= (w_cmd_n != '0) ? cmd_base : '0;
            end else if (r_state == ST_ISSUE) begin
                if (w_issue_last) begin
                    r_enb   <= 1'b0;
                    r_addrb <= '0;
                end else begin
                    r_idx   <= w_next_idx;
                    r_c     <= r_c + SEQ_CNT_DW'(1);
                    r_enb   <= 1'b1;
                    r_addrb <= r_base + w_next_off;
                end
            end
        end
    end

    // Latency-matching delay line; idle slots carry zeros
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (sys_rst) begin
                        r_pipe_c[gi]   <= '0;
                        r_pipe_sel[gi] <= '0;
                    end else begin
                        r_pipe_c[gi]   <= r_enb ? r_c   : '0;
                        r_pipe_sel[gi] <= r_enb ? r_sel : '0;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (sys_rst) begin
                        r_pipe_c[gi]   <= '0;
                        r_pipe_sel[gi] <= '0;
                    end else begin
                        r_pipe_c[gi]   <= r_pipe_c[gi-1];
                        r_pipe_sel[gi] <= r_pipe_sel[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign cmd_ready    = (r_state == ST_IDLE);
    assign busy         = ~cmd_ready;
    assign done         = r_done;
    assign l_k_0        = r_l_k_0;
    assign TB_enb       = r_enb;
    assign TB_addrb     = r_addrb;
    assign seq_cnt_out  = r_pipe_c[RD_LAT-1];
    assign TB_doutb_sel = r_pipe_sel[RD_LAT-1];

endmodule

// File: tb/tb_tb_doutb_seq_ctrl.sv
// Directed bench for the TB port-B read sequencer (RD_LAT = 1).
module tb_tb_doutb_seq_ctrl;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic       cmd_l_k_0;
    logic [9:0] cmd_base;
    logic [4:0] cmd_len;
    logic       TB_enb;
    logic [9:0] TB_addrb;
    logic [4:0] TB_doutb_sel;
    logic [4:0] seq_cnt_out;
    logic       l_k_0;
    logic       busy;
    logic       done;

    int n_total = 0;
    int n_bad   = 0;
    int acc_cnt = 0;

    logic [9:0] exp_addr [8];

    always #5 clk = ~clk;

    tb_doutb_seq_ctrl dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_l_k_0    (cmd_l_k_0),
        .cmd_base     (cmd_base),
        .cmd_len      (cmd_len),
        .TB_enb       (TB_enb),
        .TB_addrb     (TB_addrb),
        .TB_doutb_sel (TB_doutb_sel),
        .seq_cnt_out  (seq_cnt_out),
        .l_k_0        (l_k_0),
        .busy         (busy),
        .done         (done)
    );

    // count accepted commands
    always @(posedge clk) begin
        if (!sys_rst && cmd_valid && cmd_ready) acc_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Offer one command at a negedge, then check every cycle up to done.
    // k counts cycles after the accept cycle T.
    task automatic run_cmd(input string name, input logic [2:0] op, input logic lk,
                           input logic [9:0] base, input logic [4:0] len,
                           input int n, input logic [4:0] c0, input logic [4:0] sel);
        int bad0;
        bad0 = n_bad;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_l_k_0 = lk;
        cmd_base  = base;
        cmd_len   = len;
        chk({name, ".ready"}, 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= n + 2; k++) begin
            chk($sformatf("%s.enb@%0d", name, k), 32'(TB_enb), 32'(k <= n));
            chk($sformatf("%s.addr@%0d", name, k), 32'(TB_addrb),
                (k <= n) ? 32'(exp_addr[k-1]) : 32'd0);
            chk($sformatf("%s.seq@%0d", name, k), 32'(seq_cnt_out),
                (k >= 2 && k <= n + 1) ? 32'(c0) + 32'(k - 2) : 32'd0);
            chk($sformatf("%s.sel@%0d", name, k), 32'(TB_doutb_sel),
                (k >= 2 && k <= n + 1) ? 32'(sel) : 32'd0);
            chk($sformatf("%s.done@%0d", name, k), 32'(done), 32'(k == n + 2));
            chk($sformatf("%s.ready@%0d", name, k), 32'(cmd_ready), 32'(k == n + 2));
            chk($sformatf("%s.lk@%0d", name, k), 32'(l_k_0), 32'(lk));
            if (k < n + 2) @(negedge clk);
        end
        $display("cmd %s op=%0d base=%03h len=%0d reads=%0d errors=%0d",
                 name, op, base, len, n, n_bad - bad0);
    endtask

    initial begin
        int a0;
        sys_rst   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_l_k_0 = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        repeat (3) @(negedge clk);
        chk("rst.ready", 32'(cmd_ready), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.enb", 32'(TB_enb), 32'd0);
        chk("rst.addr", 32'(TB_addrb), 32'd0);
        chk("rst.sel", 32'(TB_doutb_sel), 32'd0);
        chk("rst.seq", 32'(seq_cnt_out), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.lk", 32'(l_k_0), 32'd0);
        $display("reset state checked");
        sys_rst = 1'b0;

        exp_addr[0] = 10'h010; exp_addr[1] = 10'h011;
        exp_addr[2] = 10'h012; exp_addr[3] = 10'h013;
        run_cmd("b_pos", 3'd0, 1'b0, 10'h010, 5'd4, 4, 5'd0, 5'b00101);

        exp_addr[0] = 10'h3FF; exp_addr[1] = 10'h000;
        run_cmd("b_neg_wrap", 3'd1, 1'b0, 10'h3FF, 5'd2, 2, 5'd0, 5'b00110);

        exp_addr[0] = 10'h200; exp_addr[1] = 10'h201; exp_addr[2] = 10'h202;
        run_cmd("b_new", 3'd2, 1'b1, 10'h200, 5'd3, 3, 5'd0, 5'b00111);

        exp_addr[0] = 10'h020; exp_addr[1] = 10'h021; exp_addr[2] = 10'h022;
        exp_addr[3] = 10'h023; exp_addr[4] = 10'h023; exp_addr[5] = 10'h023;
        exp_addr[6] = 10'h023;
        run_cmd("cov_ht", 3'd4, 1'b1, 10'h020, 5'd0, 7, 5'd4, 5'b11000);

        exp_addr[0] = 10'h040; exp_addr[1] = 10'h041; exp_addr[2] = 10'h041;
        run_cmd("h_lv_h", 3'd3, 1'b0, 10'h040, 5'd9, 3, 5'd12, 5'b10100);

        a0 = acc_cnt;
        run_cmd("b_pos_len0", 3'd0, 1'b1, 10'h055, 5'd0, 0, 5'd0, 5'b00000);
        run_cmd("illegal6", 3'd6, 1'b0, 10'h066, 5'd5, 0, 5'd0, 5'b00000);
        chk("len0_illegal.accepts", 32'(acc_cnt - a0), 32'd2);

        // cmd_valid held through a whole command: one accept per done
        @(negedge clk);
        a0 = acc_cnt;
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_l_k_0 = 1'b0;
        cmd_base  = 10'h100;
        cmd_len   = 5'd1;
        @(negedge clk);                                   // T+1
        chk("hold.enb1", 32'(TB_enb), 32'd1);
        chk("hold.ready1", 32'(cmd_ready), 32'd0);
        @(negedge clk);                                   // T+2
        chk("hold.seq2", 32'(TB_doutb_sel), 32'b00101);
        chk("hold.accepts2", 32'(acc_cnt - a0), 32'd1);
        @(negedge clk);                                   // T+3: done, re-accept
        chk("hold.done3", 32'(done), 32'd1);
        chk("hold.ready3", 32'(cmd_ready), 32'd1);
        @(negedge clk);                                   // T+4
        cmd_valid = 1'b0;
        chk("hold.enb4", 32'(TB_enb), 32'd1);
        chk("hold.addr4", 32'(TB_addrb), 32'h100);
        chk("hold.done4", 32'(done), 32'd0);
        chk("hold.accepts4", 32'(acc_cnt - a0), 32'd2);
        repeat (2) @(negedge clk);                        // T+6: second done
        chk("hold.done6", 32'(done), 32'd1);
        @(negedge clk);
        chk("hold.idle7", 32'(TB_enb), 32'd0);
        chk("hold.accepts7", 32'(acc_cnt - a0), 32'd2);
        $display("cmd hold_valid accepts=%0d", acc_cnt - a0);

        // reset mid cov_HT at T+3
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_l_k_0 = 1'b1;
        cmd_base  = 10'h020;
        @(negedge clk);                                   // T+1
        cmd_valid = 1'b0;
        @(negedge clk);                                   // T+2
        @(negedge clk);                                   // T+3
        chk("mid.enb3", 32'(TB_enb), 32'd1);
        chk("mid.addr3", 32'(TB_addrb), 32'h022);
        chk("mid.seq3", 32'(seq_cnt_out), 32'd5);
        sys_rst = 1'b1;
        @(negedge clk);                                   // T+4
        sys_rst = 1'b0;
        chk("mid.enb4", 32'(TB_enb), 32'd0);
        chk("mid.addr4", 32'(TB_addrb), 32'd0);
        chk("mid.sel4", 32'(TB_doutb_sel), 32'd0);
        chk("mid.seq4", 32'(seq_cnt_out), 32'd0);
        chk("mid.lk4", 32'(l_k_0), 32'd0);
        chk("mid.ready4", 32'(cmd_ready), 32'd1);
        chk("mid.busy4", 32'(busy), 32'd0);
        chk("mid.done4", 32'(done), 32'd0);
        for (int k = 5; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("mid.done@%0d", k), 32'(done), 32'd0);
            chk($sformatf("mid.enb@%0d", k), 32'(TB_enb), 32'd0);
        end
        $display("cmd reset_mid_cov_ht checked");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout: run did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
